// File: rtl/uart_byte_tx.sv
// uart_byte_tx: serialises one byte per accept as start, LSB-first data, optional parity and stop bits.
// Every output is registered and the frame ends with a one-cycle transmissionDone pulse.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dataIn,
    input  logic       transmissionStart,
    output logic       tx,
    output logic       busy,
    output logic       transmissionDone
);
    localparam int BW = $clog2(CLKS_PER_BIT * STOP_BITS);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(CLKS_PER_BIT * STOP_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t        state, state_n;
    logic [BW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    data;
    logic          par_bit, last, accept, tx_n, busy_n, done_n;

    assign accept = state == S_IDLE && transmissionStart;
    // The stop state stretches over all stop bits with one count instead of repeating per bit.
    assign last   = baud_cnt == (state == S_STOP ? STOP_LAST : BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            baud_cnt         <= '0;
            bit_idx          <= '0;
            data             <= '0;
            par_bit          <= 1'b0;
            tx               <= 1'b1;
            busy             <= 1'b0;
            transmissionDone <= 1'b0;
        end else begin
            state            <= state_n;
            baud_cnt         <= baud_cnt_n;
            bit_idx          <= bit_idx_n;
            if (accept) begin
                data    <= dataIn;
                par_bit <= ^dataIn ^ (PARITY == 2);
            end
            tx               <= tx_n;
            busy             <= busy_n;
            transmissionDone <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = accept ? S_START : S_IDLE;
            S_START: state_n = last ? S_DATA : S_START;
            S_DATA:  state_n = (last && bit_idx == 3'd7) ? (PARITY != 0 ? S_PAR : S_STOP) : S_DATA;
            S_PAR:   state_n = last ? S_STOP : S_PAR;
            S_STOP:  state_n = last ? S_IDLE : S_STOP;
            default: state_n = S_IDLE;
        endcase
        baud_cnt_n = (state == S_IDLE || last) ? '0 : baud_cnt + 1'b1;
        bit_idx_n  = state == S_DATA ? ((last && bit_idx != 3'd7) ? bit_idx + 3'd1 : bit_idx) : 3'd0;
    end

    // Outputs are computed from the next state so they change on the same edge as the state.
    always_comb begin
        tx_n   = state_n == S_START ? 1'b0 :
                 state_n == S_DATA  ? data[bit_idx_n] :
                 state_n == S_PAR   ? par_bit : 1'b1;
        busy_n = state_n != S_IDLE;
        done_n = state == S_STOP && last;
    end
endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: three configurations driven by directed and random stimulus; a monitor per
// instance decodes the line against frames queued by the stimulus.
module tb_uart_byte_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] start = '0;
    logic [7:0] din [3];
    logic [2:0] tx_w, busy_w, done_w;

    int cpb_a [3] = '{4, 4, 4};
    int par_a [3] = '{0, 1, 2};
    int sb_a  [3] = '{1, 1, 2};

    int checks = 0;
    int errors = 0;
    int ndone     [3] = '{0, 0, 0};
    int exp_done  [3] = '{0, 0, 0};
    logic [8:0] q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    uart_byte_tx #(.CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .dataIn(din[0]), .transmissionStart(start[0]),
        .tx(tx_w[0]), .busy(busy_w[0]), .transmissionDone(done_w[0]));
    uart_byte_tx #(.CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .dataIn(din[1]), .transmissionStart(start[1]),
        .tx(tx_w[1]), .busy(busy_w[1]), .transmissionDone(done_w[1]));
    uart_byte_tx #(.CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u2 (
        .clk(clk), .rst(rst), .dataIn(din[2]), .transmissionStart(start[2]),
        .tx(tx_w[2]), .busy(busy_w[2]), .transmissionDone(done_w[2]));

    task automatic chk(input int d, input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL dut%0d %s at %0t: got %0h want %0h", d, name, $time, act, exp);
        end
    endtask

    task automatic q_push(input int d, input logic [8:0] e);
        if (d == 0) q0.push_back(e);
        else if (d == 1) q1.push_back(e);
        else q2.push_back(e);
    endtask

    function automatic logic [8:0] q_pop(input int d);
        if (d == 0) return q0.pop_front();
        if (d == 1) return q1.pop_front();
        return q2.pop_front();
    endfunction

    function automatic int q_size(input int d);
        return d == 0 ? q0.size() : d == 1 ? q1.size() : q2.size();
    endfunction

    // Decodes every sample of a frame against the expected bit pattern built from the byte.
    task automatic monitor(input int d);
        int cpb, par, len, n;
        logic [8:0] e;
        logic [11:0] bits;
        logic aborted;
        time last_done;
        cpb = cpb_a[d];
        par = par_a[d];
        len = 1 + 8 + (par != 0 ? 1 : 0) + sb_a[d];
        last_done = 0;
        forever begin
            @(negedge clk);
            if (rst) continue;
            if (done_w[d] || (busy_w[d] && tx_w[d]))
                chk(d, "idle_outputs", {busy_w[d], done_w[d]}, 0);
            if (tx_w[d] == 1'b0) begin
                if (q_size(d) == 0) begin
                    chk(d, "unexpected_frame", 1, 0);
                    n = 0;
                    while (busy_w[d] && n < 1000) begin @(negedge clk); n++; end
                end else begin
                    e = q_pop(d);
                    if (e[8]) chk(d, "idle_gap_cycles", int'(($time - last_done) / 10), 1);
                    bits = '1;
                    bits[0] = 1'b0;
                    bits[8:1] = e[7:0];
                    if (par != 0) bits[9] = (^e[7:0]) ^ (par == 2);
                    aborted = 1'b0;
                    for (int s = 0; s < len * cpb; s++) begin
                        if (s > 0) @(negedge clk);
                        if (rst) begin aborted = 1'b1; break; end
                        chk(d, "frame_sample", {busy_w[d], done_w[d], tx_w[d]}, {2'b10, bits[s / cpb]});
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        if (!rst) begin
                            chk(d, "frame_end", {busy_w[d], done_w[d], tx_w[d]}, 3'b011);
                            last_done = $time;
                            if (done_w[d]) ndone[d]++;
                        end
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);
    initial monitor(2);

    task automatic wait_idle(input int d);
        int n = 0;
        while (busy_w[d] && n < 3000) begin @(negedge clk); n++; end
        if (busy_w[d]) chk(d, "idle_timeout", 1, 0);
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        do begin @(negedge clk); n++; end while (!done_w[d] && n < 3000);
        if (!done_w[d]) chk(d, "done_timeout", 1, 0);
    endtask

    // Called on a negedge where the instance is idle; the accept happens at the next posedge.
    task automatic send(input int d, input logic [7:0] b, input logic b2b);
        din[d] = b;
        start[d] = 1'b1;
        q_push(d, {b2b, b});
        exp_done[d]++;
        @(negedge clk);
        start[d] = 1'b0;
        din[d] = 8'($urandom);
    endtask

    task automatic rand_run(input int d);
        for (int i = 0; i < 6; i++) begin
            wait_idle(d);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(d, 8'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
                if (busy_w[d]) begin
                    din[d] = 8'($urandom);
                    start[d] = 1'b1;
                    @(negedge clk);
                    start[d] = 1'b0;
                end
            end
        end
        wait_idle(d);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [39:0] chain;
        for (int d = 0; d < 3; d++) din[d] = 8'h00;
        #23;
        for (int d = 0; d < 3; d++) chk(d, "reset_state", {busy_w[d], done_w[d], tx_w[d]}, 3'b001);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        send(0, 8'h55, 1'b0);
        wait_idle(0);
        repeat (3) @(negedge clk);

        send(0, 8'hA3, 1'b0);
        repeat (5) @(negedge clk);
        din[0] = 8'hFF;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_idle(0);
        repeat (10) @(negedge clk);

        fork
            send(1, 8'h07, 1'b0);
            send(2, 8'h07, 1'b0);
        join
        wait_idle(1);
        wait_idle(2);
        repeat (3) @(negedge clk);

        chain = 40'h1122334455;
        send(0, chain[7:0], 1'b0);
        for (int i = 1; i < 5; i++) begin
            wait_done(0);
            chain = chain >> 8;
            din[0] = chain[7:0];
            start[0] = 1'b1;
            q_push(0, {1'b1, chain[7:0]});
            exp_done[0]++;
            @(negedge clk);
            start[0] = 1'b0;
        end
        wait_idle(0);
        repeat (3) @(negedge clk);

        send(0, 8'h00, 1'b0);
        repeat (17) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk(0, "async_abort", {busy_w[0], done_w[0], tx_w[0]}, 3'b001);
        exp_done[0]--;
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk(0, "post_abort_idle", {busy_w[0], done_w[0], tx_w[0]}, 3'b001);
        send(0, 8'h3C, 1'b0);
        wait_idle(0);
        repeat (3) @(negedge clk);

        q_push(0, {1'b0, 8'h0F});
        q_push(0, {1'b1, 8'h0F});
        q_push(0, {1'b1, 8'h0F});
        exp_done[0] += 3;
        din[0] = 8'h0F;
        start[0] = 1'b1;
        wait_done(0);
        wait_done(0);
        @(negedge clk);
        start[0] = 1'b0;
        wait_idle(0);
        repeat (3) @(negedge clk);

        fork
            rand_run(0);
            rand_run(1);
            rand_run(2);
        join
        repeat (20) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk(d, "done_count", ndone[d], exp_done[d]);
            chk(d, "queue_empty", q_size(d), 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
Serialises one byte at a time onto an asynchronous UART line. It sits directly downstream of the DataSender stage:
- Consumes its 8-bit dataOut on a start strobe.
- Returns a one-cycle transmissionDone pulse when the frame, including stop bits, has fully left the pin, which advances DataSender to its next byte.

Frame format: start bit, LSB-first data, optional parity, stop bits.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range ≥2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- dataIn  input  8  byte to transmit; sampled only on frame accept.
- transmissionStart  input  1  request to send dataIn; level-sampled.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress.
- transmissionDone  output  1  one-cycle pulse at end of frame.

Behaviour:
- Reset (async, immediate): tx=1, busy=0, transmissionDone=0, state=IDLE, all counters cleared. Reset mid-frame aborts the frame: tx returns high at once and no done pulse is issued.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - If transmissionStart=1 at a rising edge, at that edge: latch dataIn into the shift register, compute the parity bit, set state=START, tx=0, busy=1, baud_cnt=0.
  - Otherwise tx=1.
- Every non-IDLE state holds tx for exactly CLKS_PER_BIT cycles, counted with baud_cnt 0..CLKS_PER_BIT-1. The state advances on the edge where baud_cnt=CLKS_PER_BIT-1.
- START → DATA: tx=data[0].
- DATA: bit_idx counts 0..7, and tx=data[bit_idx] at each bit boundary. After bit 7, go to PARITY if PARITY≠0, else STOP.
- PARITY: tx = XOR of the 8 data bits for even parity, or its inverse for odd.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final edge: state=IDLE, busy=0, transmissionDone=1.
- transmissionDone is high for exactly one cycle and is then cleared.
- Frame length: tx is low at edge k. transmissionDone rises at edge k + (1+8+P+STOP_BITS)*CLKS_PER_BIT, where P=1 if parity is enabled.
- transmissionStart while busy=1 is ignored; no queuing.
- dataIn changes while busy=1 have no effect on the frame in flight.
- Back-to-back frames: transmissionStart high in the cycle where transmissionDone=1 (state is already IDLE) is accepted at the next edge. The resulting inter-frame gap is stop bits plus exactly one idle-high cycle.
- transmissionStart held high continuously:
  - One frame per accept.
  - Re-accepted on the first IDLE edge.
  - dataIn is re-sampled at each accept.
- Counter widths: baud_cnt is clog2(CLKS_PER_BIT*STOP_BITS) bits; bit_idx is 3 bits. Neither counter ever wraps past its terminal value.

Test Plan:
1. CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1: reset, then send dataIn=0x55 with a one-cycle start. Required response:
   - tx per 4-cycle bit: 0, 1,0,1,0,1,0,1,0, 1.
   - busy high for 40 cycles.
   - transmissionDone pulses once, 40 cycles after tx falls.
2. Same config: send 0xA3; after the start bit, change dataIn to 0xFF and pulse transmissionStart. Required response:
   - Data bits are 1,1,0,0,0,1,0,1 (0xA3, LSB first).
   - The second start is ignored: no second frame and exactly one done pulse.
3. PARITY=1 and a second instance with PARITY=2, STOP_BITS=2: send 0x07. Required response:
   - Parity bit is 1 (even config) and 0 (odd config).
   - Frame lengths are 44 and 48 cycles respectively.
4. Chain to DataSender with dataIn=0x1122334455. Required response:
   - Decoded bytes on tx, in order: 0x55, 0x44, 0x33, 0x22, 0x11.
   - Five done pulses.
   - Each inter-frame idle gap is stop bit + 1 cycle.
5. Assert rst during data bit 3 of a 0x00 frame. Required response:
   - tx=1 in the same cycle (asynchronous).
   - busy=0, no transmissionDone.
   - The next start sends a complete, correct frame.
6. Hold transmissionStart high with dataIn=0x0F. Required response:
   - Consecutive frames are separated by exactly 1 idle cycle after the stop bit.
   - One done pulse per frame.
